// File: rtl/unified_mem_responder.sv
// Unified instruction/data memory responder.
// One shared byte-addressed store serves a fetch port and a load/store port,
// with a single access in flight and a fixed request-to-ack latency.
module unified_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              busy
);

  localparam int         MEM_BYTES = 1 << ADDR_W;
  localparam logic [2:0] CNT_INIT  = 3'(LATENCY - 1);
  localparam logic [31:0] NOP_WORD = 32'h0000_0033;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              is_d_q, is_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_err_q, if_err_d;
  logic              d_err_q, d_err_d;

  logic [7:0] mem [MEM_BYTES];

  logic              acc_is_d;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [2:0]        acc_funct3;
  logic [31:0]       acc_wdata;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       load_val;
  logic              d_bad;
  logic              f_bad;
  logic [3:0]        wr_lanes;
  logic [31:0]       wr_word;

  // Pick the access being serviced: live inputs while idle (data port wins), latched copy afterwards
  always_comb begin
    if (state_q == IDLE) begin
      acc_is_d   = d_req;
      acc_addr   = d_req ? d_addr : if_addr;
      acc_we     = d_req & d_we;
      acc_funct3 = d_funct3;
      acc_wdata  = d_wdata;
    end else begin
      acc_is_d   = is_d_q;
      acc_addr   = addr_q;
      acc_we     = we_q;
      acc_funct3 = funct3_q;
      acc_wdata  = wdata_q;
    end
  end

  // Read the aligned word, apply width/alignment legality, build load result and store lanes
  always_comb begin
    rd_word  = {mem[{acc_addr[ADDR_W-1:2], 2'd3}], mem[{acc_addr[ADDR_W-1:2], 2'd2}],
                mem[{acc_addr[ADDR_W-1:2], 2'd1}], mem[{acc_addr[ADDR_W-1:2], 2'd0}]};
    rd_shift = rd_word >> {acc_addr[1:0], 3'b000};
    f_bad    = (acc_addr[1:0] != 2'b00);
    case (acc_funct3)
      3'b000, 3'b100: d_bad = acc_we & acc_funct3[2];
      3'b001, 3'b101: d_bad = acc_addr[0] | (acc_we & acc_funct3[2]);
      3'b010:         d_bad = (acc_addr[1:0] != 2'b00);
      default:        d_bad = 1'b1;
    endcase
    case (acc_funct3)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, rd_shift[7:0]};
      3'b101:  load_val = {16'h0, rd_shift[15:0]};
      default: load_val = 32'h0;
    endcase
    case (funct3_q)
      3'b000:  wr_lanes = 4'b0001 << addr_q[1:0];
      3'b001:  wr_lanes = 4'b0011 << addr_q[1:0];
      3'b010:  wr_lanes = 4'b1111;
      default: wr_lanes = 4'b0000;
    endcase
    wr_word = wdata_q << {addr_q[1:0], 3'b000};
  end

  // Sequencing, request capture and response formation for the next cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_d_d     = is_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_err_d   = if_err_q;
    d_err_d    = d_err_q;
    case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          is_d_d   = acc_is_d;
          addr_d   = acc_addr;
          we_d     = acc_we;
          funct3_d = acc_funct3;
          wdata_d  = acc_wdata;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == RESP) begin
      if (acc_is_d) begin
        d_ack_d   = 1'b1;
        d_err_d   = d_bad;
        d_rdata_d = (d_bad || acc_we) ? 32'h0 : load_val;
      end else begin
        if_ack_d   = 1'b1;
        if_err_d   = f_bad;
        if_rdata_d = f_bad ? NOP_WORD : rd_word;
      end
    end
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      is_d_q     <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      wdata_q    <= 32'h0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_d_q     <= is_d_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_err_q   <= if_err_d;
      d_err_q    <= d_err_d;
    end
  end

  // Store commit on the edge that ends the response cycle; storage itself is never reset
  always_ff @(posedge clk) begin
    if (state_q == RESP && is_d_q && we_q && !d_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lanes[i]) begin
          mem[{addr_q[ADDR_W-1:2], 2'(i)}] <= wr_word[8*i +: 8];
        end
      end
    end
  end

  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_err   = if_err_q;
  assign d_err    = d_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench for unified_mem_responder: directed scenarios plus
// randomized traffic compared against a byte-array reference model.
module tb_unified_mem_responder;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = 8'h0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = 3'd0;
  logic [7:0]  d_addr = 8'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]  modelMem [256];
  logic [31:0] lastIfData = 32'h0;
  logic [31:0] lastDData = 32'h0;
  bit          lastIfErr = 1'b0;
  bit          lastDErr = 1'b0;
  bit          lastDKnown = 1'b1;

  int          dSeen, ifSeen, cyc;
  bit          bothAck;
  logic [31:0] expD, expF;
  bit          eD, eF;

  unified_mem_responder #(.ADDR_W(8), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .busy(busy)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic void modelData(input bit we, input logic [2:0] f3, input logic [7:0] addr,
                                    output logic [31:0] rdata, output bit err);
    int size;
    longint v;
    bit illegal;
    size = accessSize(f3);
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    err = illegal || ((int'(addr) % size) != 0);
    rdata = 32'h0;
    if (!err && !we) begin
      v = 0;
      for (int k = 0; k < size; k++) v += longint'(modelMem[8'(int'(addr) + k)]) << (8 * k);
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
      rdata = 32'(v);
    end
  endfunction

  function automatic void modelFetch(input logic [7:0] addr, output logic [31:0] rdata, output bit err);
    err = (int'(addr) % 4) != 0;
    rdata = 32'h0000_0033;
    if (!err) begin
      rdata = 32'h0;
      for (int k = 0; k < 4; k++) rdata = rdata | (32'(modelMem[8'(int'(addr) + k)]) << (8 * k));
    end
  endfunction

  task automatic applyStimulus(input bit isData, input bit we, input logic [2:0] f3,
                               input logic [7:0] addr, input logic [31:0] wdata);
    logic [31:0] expData;
    bit expErr;
    int n;
    bit gotAck;
    bit otherAck;
    if (isData) modelData(we, f3, addr, expData, expErr);
    else modelFetch(addr, expData, expErr);
    @(negedge clk);
    if (isData) begin
      d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    n = 0; gotAck = 1'b0; otherAck = 1'b0;
    while (!gotAck && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      gotAck = isData ? d_ack : if_ack;
      if (isData ? if_ack : d_ack) otherAck = 1'b1;
      if (!gotAck && n == 1) begin
        if (isData) begin
          d_we = 1'($urandom); d_funct3 = 3'($urandom); d_addr = 8'($urandom); d_wdata = $urandom;
        end else begin
          if_addr = 8'($urandom);
        end
      end
    end
    d_req = 1'b0;
    if_req = 1'b0;
    checkOutput("ack_latency", 32'(n), 32'(LATENCY));
    checkOutput("wrong_port_ack", 32'(otherAck), 32'h0);
    if (isData) begin
      checkOutput("d_err", 32'(d_err), 32'(expErr));
      if (expErr || !we) begin
        checkOutput("d_rdata", d_rdata, expData);
        lastDData = expData;
        lastDKnown = 1'b1;
      end else begin
        lastDKnown = 1'b0;
      end
      lastDErr = expErr;
      if (we && !expErr)
        for (int k = 0; k < accessSize(f3); k++) modelMem[8'(int'(addr) + k)] = wdata[8*k +: 8];
      checkOutput("if_rdata_hold", if_rdata, lastIfData);
      checkOutput("if_err_hold", 32'(if_err), 32'(lastIfErr));
    end else begin
      checkOutput("if_err", 32'(if_err), 32'(expErr));
      checkOutput("if_rdata", if_rdata, expData);
      lastIfData = expData;
      lastIfErr = expErr;
      if (lastDKnown) checkOutput("d_rdata_hold", d_rdata, lastDData);
      checkOutput("d_err_hold", 32'(d_err), 32'(lastDErr));
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("ack_one_cycle", 32'({d_ack, if_ack}), 32'h0);
    checkOutput("busy_idle", 32'(busy), 32'h0);
  endtask

  // Main sequence: reset, fill storage, directed scenarios, random traffic
  initial begin
    logic [7:0] ra;
    logic [2:0] rf;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_if_ack", 32'(if_ack), 32'h0);
    checkOutput("rst_d_ack", 32'(d_ack), 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    checkOutput("rst_errs", 32'({if_err, d_err}), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;

    for (int w = 0; w < 64; w++) applyStimulus(1'b1, 1'b1, 3'b010, 8'(w * 4), $urandom);

    applyStimulus(1'b1, 1'b1, 3'b010, 8'h10, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 3'b010, 8'h10, 32'h0);
    checkOutput("lw_deadbeef", d_rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 3'b000, 8'h13, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 3'b000, 8'h13, 32'h0);
    checkOutput("lb_sext", d_rdata, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 3'b100, 8'h13, 32'h0);
    checkOutput("lbu_zext", d_rdata, 32'h00000080);
    applyStimulus(1'b1, 1'b0, 3'b010, 8'h10, 32'h0);
    checkOutput("lw_after_sb", d_rdata, 32'h80ADBEEF);

    modelData(1'b0, 3'b010, 8'h10, expD, eD);
    modelFetch(8'h00, expF, eF);
    dSeen = 0; ifSeen = 0; cyc = 0; bothAck = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h00;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 8'h10;
    while (ifSeen == 0 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (d_ack && if_ack) bothAck = 1'b1;
      if (d_ack) begin
        dSeen = cyc;
        d_req = 1'b0;
        checkOutput("arb_d_rdata", d_rdata, expD);
      end
      if (if_ack) begin
        ifSeen = cyc;
        if_req = 1'b0;
        checkOutput("arb_if_rdata", if_rdata, expF);
      end
    end
    d_req = 1'b0;
    if_req = 1'b0;
    checkOutput("arb_both_acks", 32'(bothAck), 32'h0);
    checkOutput("arb_d_first", 32'(dSeen), 32'(LATENCY));
    checkOutput("arb_if_later", 32'(ifSeen), 32'(2 * LATENCY + 1));
    lastDData = expD; lastDErr = eD; lastDKnown = 1'b1;
    lastIfData = expF; lastIfErr = eF;
    @(posedge clk);
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 3'b001, 8'h11, 32'h0);
    checkOutput("lh_misaligned_err", 32'(d_err), 32'h1);
    applyStimulus(1'b1, 1'b1, 3'b010, 8'h12, 32'h12345678);
    checkOutput("sw_misaligned_err", 32'(d_err), 32'h1);
    applyStimulus(1'b1, 1'b0, 3'b010, 8'h10, 32'h0);
    checkOutput("lw_unchanged", d_rdata, 32'h80ADBEEF);
    applyStimulus(1'b0, 1'b0, 3'b000, 8'h02, 32'h0);
    checkOutput("fetch_misaligned_err", 32'(if_err), 32'h1);
    checkOutput("fetch_nop", if_rdata, 32'h00000033);

    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 8'h20; d_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy_wait", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("abort_busy_clear", 32'(busy), 32'h0);
    checkOutput("abort_no_ack", 32'(d_ack), 32'h0);
    checkOutput("abort_d_rdata", d_rdata, 32'h0);
    checkOutput("abort_if_rdata", if_rdata, 32'h0);
    d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abort_no_ack_later", 32'(d_ack), 32'h0);
    lastDData = 32'h0; lastDErr = 1'b0; lastDKnown = 1'b1;
    lastIfData = 32'h0; lastIfErr = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, 8'h20, 32'h0);

    for (int t = 0; t < 150; t++) begin
      ra = 8'($urandom);
      if ($urandom_range(2) != 0) ra = ra & 8'hFC;
      rf = 3'($urandom);
      if ($urandom_range(3) == 0) applyStimulus(1'b0, 1'b0, 3'b000, ra, 32'h0);
      else applyStimulus(1'b1, 1'($urandom), rf, ra, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
